// File: rtl/keypad_pkg.sv
// Shared keypad definitions: debouncer state encoding, row count and a
// one-hot-or-zero helper that the key scanner also uses.
package keypad_pkg;

  localparam int unsigned KP_ROWS = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } kd_state_t;

  // True when at most one bit of v is set.
  function automatic logic onehot0(input logic [31:0] v);
    return (v & (v - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/keypad_debounce_sync2.sv
// Two-flop synchroniser for asynchronous pad inputs, async active-low reset.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_debounce.sv
// Keypad row conditioner: synchronises the raw row pads, debounces them on
// the scanner's sample strobe and emits press/release pulses plus a busy flag.
// Optional build macro: KEYPAD_DEBOUNCE_ONEHOT_EN rejects multi-row patterns.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS     = KP_ROWS,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            sample_en,
  input  logic [ROWS-1:0] rows_raw,
  output logic [ROWS-1:0] rows_clean,
  output logic            press_pulse,
  output logic            release_pulse,
  output logic            busy
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  // With a single required sample, acceptance happens on the first look.
  localparam bit              FAST    = (DEBOUNCE == 1);

  logic [ROWS-1:0]  rows_sync;
  logic [ROWS-1:0]  rows_in_c;

  kd_state_t        state_q, state_d;
  logic [ROWS-1:0]  cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROWS-1:0]  clean_q, clean_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             busy_q;

  logic [CNT_W-1:0] cnt_inc_c;
  logic             cnt_hit_c;

  sync2 #(
    .WIDTH(ROWS)
  ) u_sync (
    .clk  (clk),
    .rst_n(reset_n),
    .d_i  (rows_raw),
    .q_o  (rows_sync)
  );

  // Pattern seen by the FSM; multi-row contacts read as "no key" when filtered.
`ifdef KEYPAD_DEBOUNCE_ONEHOT_EN
  assign rows_in_c = onehot0(32'(rows_sync)) ? rows_sync : '0;
`else
  assign rows_in_c = rows_sync;
`endif

  // Saturating match counter increment and acceptance detect.
  assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign cnt_hit_c = (cnt_inc_c == CNT_MAX);

  // Next-state and output decode; only advances on sample strobes.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    clean_d   = clean_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    if (sample_en) begin
      case (state_q)
        IDLE: begin
          if (rows_in_c != '0) begin
            cand_d = rows_in_c;
            cnt_d  = CNT_ONE;
            if (FAST) begin
              state_d = HELD;
              clean_d = rows_in_c;
              press_d = 1'b1;
            end else begin
              state_d = PRESS_CHK;
            end
          end
        end

        PRESS_CHK: begin
          if (rows_in_c == '0) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (rows_in_c == cand_q) begin
            cnt_d = cnt_inc_c;
            if (cnt_hit_c) begin
              state_d = HELD;
              clean_d = cand_q;
              press_d = 1'b1;
            end
          end else begin
            cand_d = rows_in_c;
            cnt_d  = CNT_ONE;
          end
        end

        HELD: begin
          if (rows_in_c != cand_q) begin
            if (FAST) begin
              state_d   = IDLE;
              clean_d   = '0;
              release_d = 1'b1;
              cand_d    = '0;
              cnt_d     = '0;
            end else begin
              state_d = REL_CHK;
              cnt_d   = CNT_ONE;
            end
          end
        end

        REL_CHK: begin
          if (rows_in_c == cand_q) begin
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc_c;
            if (cnt_hit_c) begin
              state_d   = IDLE;
              clean_d   = '0;
              release_d = 1'b1;
              cand_d    = '0;
              cnt_d     = '0;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // State, candidate, counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      clean_q   <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign rows_clean    = clean_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_keypad_debounce.sv
// Directed bench for keypad_debounce: expected press/release events are
// queued when rows are driven and matched against the pulses as they appear.
module tb_keypad_debounce;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sample_en;
  logic [3:0] rows_raw;
  logic [3:0] rows_clean;
  logic       press_pulse;
  logic       release_pulse;
  logic       busy;

  typedef struct {
    bit          is_press;
    logic [3:0]  rows;
    int unsigned cyc;
  } ev_t;

  ev_t         sb[$];
  ev_t         ev;
  int unsigned cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  int unsigned c0;

  keypad_debounce #(
    .ROWS    (4),
    .DEBOUNCE(4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_en    (sample_en),
    .rows_raw     (rows_raw),
    .rows_clean   (rows_clean),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input bit p, input logic [3:0] r, input int unsigned c);
    ev_t e;
    e.is_press = p;
    e.rows     = r;
    e.cyc      = c;
    sb.push_back(e);
  endtask

  // One sample strobe every 8 clocks, for the given number of strobes.
  task automatic strobed(input int periods);
    repeat (periods) begin
      sample_en = 1'b1;
      tick(1);
      sample_en = 1'b0;
      tick(7);
    end
  endtask

  // Pop and compare one expected event per observed pulse cycle.
  always @(negedge clk) begin
    if (press_pulse || release_pulse) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, press_pulse, release_pulse}, 32'd0);
      end else begin
        ev = sb.pop_front();
        chk("ev_kind", {30'd0, press_pulse, release_pulse}, ev.is_press ? 32'd2 : 32'd1);
        chk("ev_rows", rows_clean, ev.rows);
        chk("ev_cyc", cyc, ev.cyc);
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    sample_en = 1'b0;
    rows_raw  = 4'b0000;
    tick(3);
    chk("rst_clean", rows_clean, 4'b0000);
    chk("rst_press", press_pulse, 1'b0);
    chk("rst_release", release_pulse, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset_n   = 1'b1;
    sample_en = 1'b1;
    tick(2);

    // Clean press and release with latency probes.
    rows_raw = 4'b0100;
    c0 = cyc;
    push(1'b1, 4'b0100, c0 + 6);
    tick(2);
    chk("t1_busy_e2", busy, 1'b0);
    tick(1);
    chk("t1_busy_e3", busy, 1'b1);
    tick(2);
    chk("t1_clean_e5", rows_clean, 4'b0000);
    tick(1);
    chk("t1_clean_e6", rows_clean, 4'b0100);
    chk("t1_press_e6", press_pulse, 1'b1);
    tick(1);
    rows_raw = 4'b0000;
    c0 = cyc;
    push(1'b0, 4'b0000, c0 + 6);
    tick(5);
    chk("t1_clean_relchk", rows_clean, 4'b0100);
    tick(1);
    chk("t1_clean_rel", rows_clean, 4'b0000);
    chk("t1_busy_rel", busy, 1'b0);
    tick(2);

    // Bounce for 10 samples, then a stable press.
    for (int i = 0; i < 10; i++) begin
      rows_raw = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      tick(1);
    end
    rows_raw = 4'b0100;
    c0 = cyc;
    push(1'b1, 4'b0100, c0 + 6);
    tick(8);
    rows_raw = 4'b0000;
    c0 = cyc;
    push(1'b0, 4'b0000, c0 + 6);
    tick(8);

    // Candidate swap while qualifying.
    rows_raw = 4'b0100;
    c0 = cyc;
    tick(2);
    rows_raw = 4'b0010;
    push(1'b1, 4'b0010, c0 + 8);
    tick(8);
    chk("t3_clean", rows_clean, 4'b0010);
    rows_raw = 4'b0000;
    c0 = cyc;
    push(1'b0, 4'b0000, c0 + 6);
    tick(8);

    // Short release glitch while held.
    rows_raw = 4'b0100;
    c0 = cyc;
    push(1'b1, 4'b0100, c0 + 6);
    tick(8);
    rows_raw = 4'b0000;
    tick(2);
    rows_raw = 4'b0100;
    tick(8);
    chk("t4_clean", rows_clean, 4'b0100);
    chk("t4_busy", busy, 1'b1);
    rows_raw = 4'b0000;
    c0 = cyc;
    push(1'b0, 4'b0000, c0 + 6);
    tick(8);

    // Slow strobe: one sample enable every 8 clocks.
    sample_en = 1'b0;
    rows_raw  = 4'b0100;
    c0 = cyc;
    push(1'b1, 4'b0100, c0 + 32);
    tick(7);
    strobed(4);
    chk("t5_clean_press", rows_clean, 4'b0100);
    rows_raw = 4'b0000;
    c0 = cyc;
    push(1'b0, 4'b0000, c0 + 32);
    tick(7);
    strobed(4);
    chk("t5_clean_rel", rows_clean, 4'b0000);
    sample_en = 1'b1;
    tick(2);

    // Reset in the middle of release qualification, key then re-held.
    rows_raw = 4'b0100;
    c0 = cyc;
    push(1'b1, 4'b0100, c0 + 6);
    tick(8);
    rows_raw = 4'b0000;
    tick(4);
    rows_raw = 4'b0100;
    reset_n  = 1'b0;
    #1;
    chk("t6_rst_clean", rows_clean, 4'b0000);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_release", release_pulse, 1'b0);
    tick(2);
    reset_n = 1'b1;
    c0 = cyc;
    push(1'b1, 4'b0100, c0 + 6);
    tick(8);
    chk("t6_requal_clean", rows_clean, 4'b0100);
    rows_raw = 4'b0000;
    c0 = cyc;
    push(1'b0, 4'b0000, c0 + 6);
    tick(8);

    // Two-row contact: filtered out or passed through depending on build.
    rows_raw = 4'b0110;
    c0 = cyc;
`ifdef KEYPAD_DEBOUNCE_ONEHOT_EN
    tick(12);
    chk("t7_busy", busy, 1'b0);
    chk("t7_clean", rows_clean, 4'b0000);
    rows_raw = 4'b0000;
    tick(4);
`else
    push(1'b1, 4'b0110, c0 + 6);
    tick(8);
    chk("t7_clean", rows_clean, 4'b0110);
    rows_raw = 4'b0000;
    c0 = cyc;
    push(1'b0, 4'b0000, c0 + 6);
    tick(8);
`endif

    tick(4);
    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
